// File: rtl/pipe_stage_hs.sv
// -----------------------------------------------------------------------------
// pipe_stage_hs
//
// Parametrised pipeline stage register with valid/ready handshaking on both
// sides. It carries an opaque payload bus and a control bus between adjacent
// CPU pipeline stages. An optional two-entry skid buffer registers in_ready,
// which breaks the combinational ready path from downstream to upstream.
// Flush squashes every held entry into a bubble: valid and control are
// cleared, so a squashed instruction cannot write architectural state.
//
// Parameters
//   DATA_W   width of the payload bus (operands, immediates); opaque here
//   CTRL_W   width of the control bus; always zero while no entry is presented
//   SKID_EN  1 = main + skid slot, in_ready registered
//            0 = single main slot, in_ready combinational from out_ready
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-high, highest priority
//   flush      squash every entry held in the stage this cycle
//   in_valid   upstream offers an entry
//   in_ready   stage can accept an entry this cycle
//   in_data    upstream payload
//   in_ctrl    upstream control
//   out_valid  stage presents an entry downstream
//   out_ready  downstream accepts the entry
//   out_data   presented payload (may be stale while out_valid = 0)
//   out_ctrl   presented control, forced to 0 while out_valid = 0
//   occupancy  number of valid entries held (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_hs #(
  parameter int DATA_W  = 48,
  parameter int CTRL_W  = 14,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // Main slot: the entry currently presented downstream.
  logic              m_v_q, m_v_d;
  logic [DATA_W-1:0] m_d_q, m_d_d;
  logic [CTRL_W-1:0] m_c_q, m_c_d;

  // Skid slot: catches the entry accepted in the cycle the main slot stalled.
  // Held permanently empty when SKID_EN = 0.
  logic              s_v_q, s_v_d;
  logic [DATA_W-1:0] s_d_q, s_d_d;
  logic [CTRL_W-1:0] s_c_q, s_c_d;

  logic acc;
  logic pop;

  // With the skid slot, ready depends only on state, so upstream never sees a
  // path from out_ready. Without it, a full main slot can still accept when
  // it is being drained in the same cycle.
  assign in_ready = SKID_EN ? ~s_v_q : (~m_v_q | out_ready);

  assign acc = in_valid & in_ready;
  assign pop = m_v_q & out_ready;

  assign out_valid = m_v_q;
  assign out_data  = m_d_q;
  // Stale control must never leak out with a bubble.
  assign out_ctrl  = m_v_q ? m_c_q : '0;

  assign occupancy = {1'b0, m_v_q} + {1'b0, s_v_q};

  always_comb begin
    m_v_d = m_v_q;
    m_d_d = m_d_q;
    m_c_d = m_c_q;
    s_v_d = s_v_q;
    s_d_d = s_d_q;
    s_c_d = s_c_q;

    if (SKID_EN) begin
      if (~m_v_q | pop) begin
        // Main slot is free this cycle. The skid entry is older than anything
        // on the input, so it always moves up first to keep order.
        if (s_v_q) begin
          m_v_d = 1'b1;
          m_d_d = s_d_q;
          m_c_d = s_c_q;
          s_v_d = 1'b0;
          if (acc) begin
            s_v_d = 1'b1;
            s_d_d = in_data;
            s_c_d = in_ctrl;
          end
        end else if (acc) begin
          m_v_d = 1'b1;
          m_d_d = in_data;
          m_c_d = in_ctrl;
        end else begin
          m_v_d = 1'b0;
        end
      end else if (acc) begin
        // Main slot stalled but in_ready was already promised last cycle:
        // park the entry in the skid slot.
        s_v_d = 1'b1;
        s_d_d = in_data;
        s_c_d = in_ctrl;
      end
    end else begin
      s_v_d = 1'b0;
      s_d_d = '0;
      s_c_d = '0;
      if (acc) begin
        m_v_d = 1'b1;
        m_d_d = in_data;
        m_c_d = in_ctrl;
      end else if (pop) begin
        m_v_d = 1'b0;
      end
    end

    // Flush overrides every load decision above: an entry offered in the
    // flush cycle is dropped, and payload registers keep their old contents
    // so only the valid/control bits toggle.
    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
      m_c_d = '0;
      s_c_d = '0;
      m_d_d = m_d_q;
      s_d_d = s_d_q;
    end
  end

  // Stage boundary: all main and skid slot state.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_v_q <= 1'b0;
      m_d_q <= '0;
      m_c_q <= '0;
      s_v_q <= 1'b0;
      s_d_q <= '0;
      s_c_q <= '0;
    end else begin
      m_v_q <= m_v_d;
      m_d_q <= m_d_d;
      m_c_q <= m_c_d;
      s_v_q <= s_v_d;
      s_d_q <= s_d_d;
      s_c_q <= s_c_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
module tb_pipe_stage_hs;

  localparam int DATA_W = 48;
  localparam int CTRL_W = 14;
  localparam int NV     = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Skid build
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [1:0]        occupancy;

  // Single-register build
  logic              z_rst, z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [DATA_W-1:0] z_in_data, z_out_data;
  logic [CTRL_W-1:0] z_in_ctrl, z_out_ctrl;
  logic [1:0]        z_occupancy;

  pipe_stage_hs #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  pipe_stage_hs #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst(z_rst), .flush(z_flush),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data), .in_ctrl(z_in_ctrl),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data), .out_ctrl(z_out_ctrl),
    .occupancy(z_occupancy)
  );

  typedef struct {
    logic              rst;
    logic              flush;
    logic              iv;
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    logic              ordy;
    logic              ev;
    logic [DATA_W-1:0] ed;
    logic [CTRL_W-1:0] ec;
    logic              eir;
    logic [1:0]        eocc;
  } vec_t;

  vec_t vt [NV];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic r, logic f, logic iv, logic [DATA_W-1:0] d,
                              logic [CTRL_W-1:0] c, logic ordy, logic ev,
                              logic [DATA_W-1:0] ed, logic [CTRL_W-1:0] ec,
                              logic eir, logic [1:0] eocc);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eir = eir; v.eocc = eocc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    //            rst f  iv d                 c        ordy| ev ed                 ec       ir occ
    // reset with an offer present
    vt[0]  = mk(1, 0, 1, 48'h55,           14'h3,    0,   0, 48'h0,           14'h0,    1, 0);
    // stream 1..4 with out_ready high
    vt[1]  = mk(0, 0, 1, 48'h1,            14'h1,    1,   1, 48'h1,           14'h1,    1, 1);
    vt[2]  = mk(0, 0, 1, 48'h2,            14'h2,    1,   1, 48'h2,           14'h2,    1, 1);
    vt[3]  = mk(0, 0, 1, 48'h3,            14'h3,    1,   1, 48'h3,           14'h3,    1, 1);
    vt[4]  = mk(0, 0, 1, 48'h4,            14'h4,    1,   1, 48'h4,           14'h4,    1, 1);
    vt[5]  = mk(0, 0, 0, 48'h0,            14'h0,    1,   0, 48'h4,           14'h0,    1, 0);
    // backpressure into skid, then drain in order
    vt[6]  = mk(0, 0, 1, 48'h0A,           14'h0A,   0,   1, 48'h0A,          14'h0A,   1, 1);
    vt[7]  = mk(0, 0, 1, 48'h0B,           14'h0B,   0,   1, 48'h0A,          14'h0A,   0, 2);
    vt[8]  = mk(0, 0, 1, 48'h0C,           14'h0C,   0,   1, 48'h0A,          14'h0A,   0, 2);
    vt[9]  = mk(0, 0, 0, 48'h0,            14'h0,    1,   1, 48'h0B,          14'h0B,   1, 1);
    vt[10] = mk(0, 0, 0, 48'h0,            14'h0,    1,   0, 48'h0B,          14'h0,    1, 0);
    // flush a full stage with an all-ones control offer
    vt[11] = mk(0, 0, 1, 48'h21,           14'h21,   0,   1, 48'h21,          14'h21,   1, 1);
    vt[12] = mk(0, 0, 1, 48'h22,           14'h22,   0,   1, 48'h21,          14'h21,   0, 2);
    vt[13] = mk(0, 1, 1, 48'h33,           14'h3FFF, 0,   0, 48'h21,          14'h0,    1, 0);
    vt[14] = mk(0, 0, 0, 48'h0,            14'h0,    1,   0, 48'h21,          14'h0,    1, 0);
    // flush drops an entry accepted in the same cycle
    vt[15] = mk(0, 1, 1, 48'h44,           14'h44,   1,   0, 48'h21,          14'h0,    1, 0);
    // simultaneous pop and accept at occupancy 1
    vt[16] = mk(0, 0, 1, 48'h11,           14'h11,   0,   1, 48'h11,          14'h11,   1, 1);
    vt[17] = mk(0, 0, 1, 48'h22,           14'h22,   1,   1, 48'h22,          14'h22,   1, 1);
    vt[18] = mk(0, 0, 0, 48'h0,            14'h0,    0,   1, 48'h22,          14'h22,   1, 1);
    // flush together with a pop
    vt[19] = mk(0, 1, 0, 48'h0,            14'h0,    1,   0, 48'h22,          14'h0,    1, 0);
    // reset mid-stream with flush and an offer
    vt[20] = mk(0, 0, 1, 48'h61,           14'h61,   0,   1, 48'h61,          14'h61,   1, 1);
    vt[21] = mk(0, 0, 1, 48'h62,           14'h62,   0,   1, 48'h61,          14'h61,   0, 2);
    vt[22] = mk(1, 1, 1, 48'h63,           14'h3FFF, 0,   0, 48'h0,           14'h0,    1, 0);
    vt[23] = mk(0, 0, 0, 48'h0,            14'h0,    1,   0, 48'h0,           14'h0,    1, 0);
    // skid drains while upstream keeps offering: the held offer waits its turn
    vt[24] = mk(0, 0, 1, 48'h71,           14'h71,   0,   1, 48'h71,          14'h71,   1, 1);
    vt[25] = mk(0, 0, 1, 48'h72,           14'h72,   0,   1, 48'h71,          14'h71,   0, 2);
    vt[26] = mk(0, 0, 1, 48'h73,           14'h73,   1,   1, 48'h72,          14'h72,   1, 1);
    vt[27] = mk(0, 0, 1, 48'h73,           14'h73,   1,   1, 48'h73,          14'h73,   1, 1);
    vt[28] = mk(0, 0, 0, 48'h0,            14'h0,    1,   0, 48'h73,          14'h0,    1, 0);
    // full-width payload and control
    vt[29] = mk(0, 0, 1, 48'hFFFFFFFFFFFF, 14'h3FFF, 0,   1, 48'hFFFFFFFFFFFF, 14'h3FFF, 1, 1);
    vt[30] = mk(0, 0, 0, 48'h0,            14'h0,    1,   0, 48'hFFFFFFFFFFFF, 14'h0,    1, 0);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    z_rst = 1'b1; z_flush = 1'b0; z_in_valid = 1'b0; z_in_data = '0; z_in_ctrl = '0;
    z_out_ready = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vt[i].rst; flush = vt[i].flush; in_valid = vt[i].iv;
      in_data = vt[i].d; in_ctrl = vt[i].c; out_ready = vt[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vt[i].ev));
      chk($sformatf("v%0d out_data", i),  64'(out_data),  64'(vt[i].ed));
      chk($sformatf("v%0d out_ctrl", i),  64'(out_ctrl),  64'(vt[i].ec));
      chk($sformatf("v%0d in_ready", i),  64'(in_ready),  64'(vt[i].eir));
      chk($sformatf("v%0d occupancy", i), 64'(occupancy), 64'(vt[i].eocc));
    end

    // Single-register build: in_ready follows out_ready within the cycle.
    @(posedge clk); #1;
    chk("z reset out_valid", 64'(z_out_valid), 64'd0);
    chk("z reset in_ready",  64'(z_in_ready),  64'd1);
    chk("z reset occupancy", 64'(z_occupancy), 64'd0);

    @(negedge clk);
    z_rst = 1'b0; z_in_valid = 1'b1; z_in_data = 48'h5; z_in_ctrl = 14'h5; z_out_ready = 1'b0;
    @(posedge clk); #1;
    chk("z load out_valid", 64'(z_out_valid), 64'd1);
    chk("z load out_data",  64'(z_out_data),  64'h5);
    chk("z load occupancy", 64'(z_occupancy), 64'd1);

    @(negedge clk);
    z_in_valid = 1'b0; z_out_ready = 1'b0;
    #1;
    chk("z stall in_ready", 64'(z_in_ready), 64'd0);
    z_out_ready = 1'b1;
    #1;
    chk("z comb in_ready", 64'(z_in_ready), 64'd1);
    z_in_valid = 1'b1; z_in_data = 48'h6; z_in_ctrl = 14'h6;
    @(posedge clk); #1;
    chk("z pop+acc out_data",  64'(z_out_data),  64'h6);
    chk("z pop+acc out_ctrl",  64'(z_out_ctrl),  64'h6);
    chk("z pop+acc occupancy", 64'(z_occupancy), 64'd1);

    @(negedge clk);
    z_in_valid = 1'b1; z_in_data = 48'h7; z_in_ctrl = 14'h7; z_out_ready = 1'b0;
    @(posedge clk); #1;
    chk("z blocked out_data",  64'(z_out_data),  64'h6);
    chk("z blocked occupancy", 64'(z_occupancy), 64'd1);

    @(negedge clk);
    z_in_valid = 1'b0; z_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("z drain out_valid", 64'(z_out_valid), 64'd0);
    chk("z drain out_ctrl",  64'(z_out_ctrl),  64'd0);
    chk("z drain occupancy", 64'(z_occupancy), 64'd0);

    @(negedge clk);
    z_in_valid = 1'b1; z_in_data = 48'h8; z_in_ctrl = 14'h3FFF; z_out_ready = 1'b0;
    @(posedge clk); #1;
    chk("z refill out_ctrl", 64'(z_out_ctrl), 64'h3FFF);

    @(negedge clk);
    z_flush = 1'b1; z_in_valid = 1'b1; z_in_data = 48'h9; z_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("z flush out_valid", 64'(z_out_valid), 64'd0);
    chk("z flush out_ctrl",  64'(z_out_ctrl),  64'd0);
    chk("z flush out_data",  64'(z_out_data),  64'h8);
    chk("z flush occupancy", 64'(z_occupancy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised pipeline stage register, the successor to the fixed-field decode/execute latch.
- Carries a generic data bus plus a control bus between adjacent CPU pipeline stages using valid/ready handshaking instead of a reset-as-stall scheme.
- Optional two-entry skid buffer breaks the combinational ready path.
- Flush inserts a bubble: valid and control bits cleared, so squashed instructions cannot write state.

Parameters:
- DATA_W, 48, width of payload bus (e.g. rd1/rd2/imm), no effect on control semantics
- CTRL_W, 14, width of control bus (reg ids, write enables, opcode flags); forced to 0 in any bubble
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  squash every entry held in the stage this cycle
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage can accept an entry this cycle
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control
- out_valid  out  1  stage presents an entry downstream
- out_ready  in  1  downstream accepts the entry
- out_data  out  DATA_W  presented payload
- out_ctrl  out  CTRL_W  presented control; 0 whenever out_valid = 0
- occupancy  out  2  number of valid entries held (0..2; max 1 when SKID_EN = 0)

Behaviour:
- State: main slot {m_v, m_d, m_c}; skid slot {s_v, s_d, s_c} (present only when SKID_EN = 1).
- Definitions:
  - acc = in_valid & in_ready
  - pop = m_v & out_ready
- Outputs:
  - out_valid = m_v
  - out_data = m_d
  - out_ctrl = m_v ? m_c : 0
- Reset (rst = 1 at edge): m_v = s_v = 0; m_d, m_c, s_d, s_c = 0. Hence out_valid = 0, out_ctrl = 0, out_data = 0, occupancy = 0, and in_ready = 1 after the edge.
- rst has priority over flush and all handshakes.
- Flush (rst = 0, flush = 1):
  - m_v = s_v = 0; m_c = s_c = 0; data registers hold.
  - An entry offered the same cycle is dropped even if acc = 1.
  - pop in the flush cycle still counts as a completed downstream transfer.
- SKID_EN = 1, normal operation:
  - in_ready = ~s_v, registered, with no combinational dependence on out_ready.
  - Main slot loads when ~m_v | pop: from skid if s_v (s_v then clears), else from input if acc, else m_v = 0.
  - If the main slot does not load and acc = 1, the entry goes to skid: s_v = 1.
  - If the main slot loads from skid and acc = 1 in the same cycle, the entry goes to skid (s_v stays 1).
  - Order is preserved: the skid entry always precedes the input entry.
  - Latency: 1 cycle input to output when empty; 100% throughput with out_ready held high.
- SKID_EN = 0:
  - in_ready = ~m_v | out_ready (combinational).
  - Main slot loads on acc; m_v clears on pop without acc.
- Boundaries:
  - Full (occupancy = 2): in_ready = 0; in_valid ignored.
  - Simultaneous pop and acc with occupancy 1: occupancy stays 1 and the new entry appears next cycle.
  - Payload on in_data/in_ctrl is don't-care while in_valid = 0.
  - out_data may hold stale data while out_valid = 0; out_ctrl may not.
- occupancy = m_v + s_v, registered-derived with no combinational inputs.

Test Plan:
- Reset then stream: rst 1 cycle, then in_valid = 1, in_data = 0x000000000001..0x000000000004 on consecutive cycles with out_ready = 1 → out_valid rises 1 cycle after the first acc; outputs 1,2,3,4 on consecutive cycles; in_ready constantly 1.
- Backpressure into skid: feed A = 0x0A, B = 0x0B with out_ready = 0 → occupancy 1 then 2, in_ready = 0 in cycle 3. Raise out_ready → A then B emitted in order and in_ready returns to 1 the cycle after the skid drains.
- Flush with full stage: occupancy = 2, in_ctrl = 0x3FFF offered, flush = 1 → next cycle out_valid = 0, out_ctrl = 0x0000, occupancy = 0, the offered entry never appears.
- Simultaneous pop/accept: occupancy 1 holding 0x11, out_ready = 1, in_valid = 1 with 0x22 → occupancy stays 1 and out_data = 0x22 next cycle.
- Reset mid-stream: occupancy 2, rst = 1 together with flush = 1 and in_valid = 1 → all outputs 0, in_ready = 1 next cycle, no entry emitted afterwards.
- SKID_EN = 0 build: m_v = 1, out_ready = 0 → in_ready = 0 in the same cycle. Toggle out_ready to 1 → in_ready = 1 combinationally, and occupancy never exceeds 1.
